if_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU, directly upstream of the IF/ID pipeline register. Owns the program counter, issues requests to instruction memory through a ready-based handshake, and presents each fetched instruction with its PC+4 to IF/ID. Handles hazard stalls, branch/jump redirects and variable memory latency, inserting NOP bubbles whenever no valid instruction is available.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, reset/bubble constants and fetch FSM states.
package cpu_pkg;

  localparam int unsigned WordWidth = 32;

  localparam logic [WordWidth-1:0] ResetPc  = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [WordWidth-1:0] NopInstr = 32'h0000_0000;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDiscard
  } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to imem over a ready handshake and
// feeds IF/ID with the fetched word and PC+4, or a NOP bubble when nothing is valid.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [WordWidth-1:0] RESET_PC  = ResetPc,
  parameter logic [WordWidth-1:0] NOP_INSTR = NopInstr
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 staller,
  input  logic                 redirect,
  input  logic [WordWidth-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [WordWidth-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic [WordWidth-1:0] imem_rdata,
  output logic [WordWidth-1:0] PC_out,
  output logic [WordWidth-1:0] idata_out,
  output logic                 fetch_valid
);

  fetch_state_e         state_q;
  logic [WordWidth-1:0] pc_q;
  logic [WordWidth-1:0] buf_instr_q;
  logic [WordWidth-1:0] buf_pc_q;
  logic [WordWidth-1:0] pending_pc_q;

  logic [WordWidth-1:0] pc_plus4;
  logic [WordWidth-1:0] buf_pc_plus4;

  assign pc_plus4     = pc_q + 32'd4;
  assign buf_pc_plus4 = buf_pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      buf_instr_q  <= '0;
      buf_pc_q     <= '0;
      pending_pc_q <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ready) begin
            if (redirect) begin
              pc_q <= redirect_pc;
            end else if (staller) begin
              buf_instr_q <= imem_rdata;
              buf_pc_q    <= pc_q;
              state_q     <= StHold;
            end else begin
              pc_q <= pc_plus4;
            end
          end else if (redirect) begin
            // Old request still outstanding: remember the target, drop the word later.
            pending_pc_q <= redirect_pc;
            state_q      <= StDiscard;
          end
        end
        StHold: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            state_q <= StFetch;
          end else if (!staller) begin
            pc_q    <= buf_pc_plus4;
            state_q <= StFetch;
          end
        end
        StDiscard: begin
          if (redirect) begin
            pending_pc_q <= redirect_pc;
          end
          if (imem_ready) begin
            pc_q    <= redirect ? redirect_pc : pending_pc_q;
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    idata_out   = NOP_INSTR;
    PC_out      = '0;
    fetch_valid = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ready && !redirect && !staller) begin
            idata_out   = imem_rdata;
            PC_out      = pc_plus4;
            fetch_valid = 1'b1;
          end
        end
        StHold: begin
          // A redirect kills the held word in the same cycle.
          if (!redirect) begin
            idata_out   = buf_instr_q;
            PC_out      = buf_pc_plus4;
            fetch_valid = 1'b1;
          end
        end
        StDiscard: begin
          imem_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed literal checks plus a randomized run
// compared every cycle against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] Nop = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        staller;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] idata_out;
  logic        fetch_valid;

  int total = 0;
  int bad   = 0;
  bit scramble = 1'b0;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .staller    (staller),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PC_out     (PC_out),
    .idata_out  (idata_out),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return scramble ? (a ^ 32'hC3A5_0F1E) : a;
  endfunction

  // Memory content is a fixed function of the address; garbage when not ready.
  assign imem_rdata = imem_ready ? word_at(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the next fetch goes, whether a word is parked for a
  // stall, and whether an in-flight word must be thrown away.
  bit          m_live = 1'b0;
  logic [31:0] m_addr;
  bit          m_held;
  logic [31:0] m_held_word;
  logic [31:0] m_held_pc;
  bit          m_squash;
  logic [31:0] m_target;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      chk("rst_idata", idata_out, Nop);
      chk("rst_pcout", PC_out, 32'd0);
      m_live   = 1'b1;
      m_addr   = 32'h0;
      m_held   = 1'b0;
      m_squash = 1'b0;
    end else if (m_live) begin
      if (m_held) begin
        chk("hold_req", 32'(imem_req), 32'd0);
        if (redirect) begin
          chk("hold_redir_valid", 32'(fetch_valid), 32'd0);
          chk("hold_redir_idata", idata_out, Nop);
          m_addr = redirect_pc;
          m_held = 1'b0;
        end else begin
          chk("hold_valid", 32'(fetch_valid), 32'd1);
          chk("hold_idata", idata_out, m_held_word);
          chk("hold_pcout", PC_out, m_held_pc + 32'd4);
          if (!staller) begin
            m_addr = m_held_pc + 32'd4;
            m_held = 1'b0;
          end
        end
      end else if (m_squash) begin
        chk("disc_req", 32'(imem_req), 32'd1);
        chk("disc_addr", imem_addr, m_addr);
        chk("disc_valid", 32'(fetch_valid), 32'd0);
        chk("disc_idata", idata_out, Nop);
        if (redirect) m_target = redirect_pc;
        if (imem_ready) begin
          m_addr   = m_target;
          m_squash = 1'b0;
        end
      end else begin
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, m_addr);
        if (imem_ready && !redirect && !staller) begin
          chk("fetch_valid", 32'(fetch_valid), 32'd1);
          chk("fetch_idata", idata_out, word_at(m_addr));
          chk("fetch_pcout", PC_out, m_addr + 32'd4);
          m_addr = m_addr + 32'd4;
        end else begin
          chk("bubble_valid", 32'(fetch_valid), 32'd0);
          chk("bubble_idata", idata_out, Nop);
          if (imem_ready && redirect) begin
            m_addr = redirect_pc;
          end else if (imem_ready) begin
            m_held      = 1'b1;
            m_held_word = word_at(m_addr);
            m_held_pc   = m_addr;
          end else if (redirect) begin
            m_squash = 1'b1;
            m_target = redirect_pc;
          end
        end
      end
    end
  end

  // Apply one cycle of inputs, then return at the sampling point of that cycle.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] rp,
                      input logic rdy);
    @(posedge clk);
    #1;
    rst         = r;
    staller     = s;
    redirect    = d;
    redirect_pc = rp;
    imem_ready  = rdy;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rp;
    rst         = 1'b1;
    staller     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b0;

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_rst_req", 32'(imem_req), 32'd0);

    // Zero-wait memory: one word per cycle.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("lit_stream_idata", idata_out, 32'(i * 4));
      chk("lit_stream_pcout", PC_out, 32'(i * 4 + 4));
      chk("lit_stream_valid", 32'(fetch_valid), 32'd1);
    end

    // Two wait cycles on 0x10.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("lit_wait_valid", 32'(fetch_valid), 32'd0);
      chk("lit_wait_addr", imem_addr, 32'h10);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_wait_idata", idata_out, 32'h10);
    chk("lit_wait_pcout", PC_out, 32'h14);

    // Stall while fetching 0x14.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("lit_stall_cap_valid", 32'(fetch_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("lit_hold_req", 32'(imem_req), 32'd0);
      chk("lit_hold_idata", idata_out, 32'h14);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_release_pcout", PC_out, 32'h18);
    chk("lit_release_valid", 32'(fetch_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_after_release_addr", imem_addr, 32'h18);

    // Redirect during an outstanding request, then retarget while discarding.
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    chk("lit_redir_valid", 32'(fetch_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_disc_addr", imem_addr, 32'h18);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_disc_drop_valid", 32'(fetch_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_retarget_addr", imem_addr, 32'h200);

    // Redirect beats stall on a completing fetch.
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
    chk("lit_redir_stall_valid", 32'(fetch_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_redir_stall_req", 32'(imem_req), 32'd1);
    chk("lit_redir_stall_addr", imem_addr, 32'h40);

    // Reset mid-wait.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_midrst_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_postrst_addr", imem_addr, 32'h0);
    chk("lit_postrst_valid", 32'(fetch_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_postrst_idata", idata_out, 32'h0);

    // PC wraps modulo 2^32.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_wrap_idata", idata_out, 32'hFFFF_FFFC);
    chk("lit_wrap_pcout", PC_out, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("lit_wrap_next", idata_out, 32'h0);

    // Randomized run against the model.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    scramble = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF8;
      else rp = 32'($urandom_range(0, 1023)) << 2;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), rp, ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
